fb_arbiter: RTL

FB_ARBITER -- requirements
Module: fb_arbiter

---
 rtl/fb_arbiter_if.sv | 41 ++++
 rtl/fb_arbiter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/fb_arbiter_if.sv
// Bundles the pixel stream, scanout read port and framebuffer RAM port of the
// framebuffer arbiter. The slave modport is the arbiter's view.
`timescale 1ns/1ps
interface fb_arbiter_if;
  logic        lcd_write;
  logic [1:0]  lcd_col;
  logic [7:0]  lcd_x;
  logic [7:0]  lcd_y;
  logic        lcd_vblank;

  logic        rd_req;
  logic [14:0] rd_addr;
  logic        rd_ack;
  logic [1:0]  rd_data;

  logic [14:0] mem_addr;
  logic        mem_we;
  logic [1:0]  mem_wdata;
  logic [1:0]  mem_rdata;

  logic        wfifo_overflow;
  logic        frame_done;

  modport slave (
    input  lcd_write, lcd_col, lcd_x, lcd_y, lcd_vblank,
    input  rd_req, rd_addr,
    output rd_ack, rd_data,
    output mem_addr, mem_we, mem_wdata,
    input  mem_rdata,
    output wfifo_overflow, frame_done
  );

  modport master (
    output lcd_write, lcd_col, lcd_x, lcd_y, lcd_vblank,
    output rd_req, rd_addr,
    input  rd_ack, rd_data,
    input  mem_addr, mem_we, mem_wdata,
    output mem_rdata,
    input  wfifo_overflow, frame_done
  );
endinterface

// File: rtl/fb_arbiter.sv
// Framebuffer arbiter: queues core pixel writes in a 4-entry FIFO and shares a
// single-port synchronous RAM between those writes and scanout reads.
`timescale 1ns/1ps
module fb_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  fb_arbiter_if.slave bus
);
  localparam int unsigned FIFO_DEPTH = 4;
  localparam logic [7:0]  X_LIMIT    = 8'd160;
  localparam logic [7:0]  Y_LIMIT    = 8'd144;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD     = 2'd1,
    RD_ACK = 2'd2,
    WR     = 2'd3
  } state_t;

  typedef struct packed {
    logic [14:0] addr;
    logic [1:0]  col;
  } pixel_t;

  state_t      state_q, state_d;
  pixel_t      fifo_q [FIFO_DEPTH];
  pixel_t      fifo_d [FIFO_DEPTH];
  logic [1:0]  wr_ptr_q, wr_ptr_d;
  logic [1:0]  rd_ptr_q, rd_ptr_d;
  logic [2:0]  count_q, count_d;
  logic [14:0] mem_addr_q, mem_addr_d;
  logic        mem_we_q, mem_we_d;
  logic [1:0]  mem_wdata_q, mem_wdata_d;
  logic        overflow_q, overflow_d;
  logic        frame_done_q, frame_done_d;
  logic        frame_armed_q, frame_armed_d;

  logic        pix_in_range;
  logic        push_req;
  logic        push;
  logic        pop;
  logic        fifo_full;
  logic        fifo_empty;
  logic [14:0] y_ext;
  logic [14:0] pix_addr;
  pixel_t      head;

  // y*160 = y*128 + y*32; max in-range result 23039 fits in 15 bits
  assign y_ext        = {7'd0, bus.lcd_y};
  assign pix_addr     = (y_ext << 7) + (y_ext << 5) + {7'd0, bus.lcd_x};
  assign pix_in_range = (bus.lcd_x < X_LIMIT) && (bus.lcd_y < Y_LIMIT);
  assign push_req     = bus.lcd_write && pix_in_range;

  assign fifo_full  = (count_q == 3'(FIFO_DEPTH));
  assign fifo_empty = (count_q == 3'd0);
  assign head       = fifo_q[rd_ptr_q];

  // The head is consumed on the edge that enters WR, so a full FIFO can still
  // take a pixel on that same edge.
  assign pop  = (state_d == WR);
  assign push = push_req && (!fifo_full || pop);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, WR: begin
        if (bus.rd_req && (count_q < 3'd3)) begin
          state_d = RD;
        end else if (!fifo_empty) begin
          state_d = WR;
        end else if (bus.rd_req) begin
          state_d = RD;
        end else begin
          state_d = IDLE;
        end
      end
      RD:      state_d = RD_ACK;
      RD_ACK:  state_d = fifo_empty ? IDLE : WR;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 2'd1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 2'd1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
    if (push_req && !push) begin
      overflow_d = 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      fifo_d[i] = fifo_q[i];
      if (push && (wr_ptr_q == 2'(i))) begin
        fifo_d[i].addr = pix_addr;
        fifo_d[i].col  = bus.lcd_col;
      end
    end
  end

  // RAM controls are launched from the next state so the RAM sees them on
  // the first edge of RD or WR.
  always_comb begin
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    case (state_d)
      RD: begin
        mem_addr_d = bus.rd_addr;
      end
      WR: begin
        mem_addr_d  = head.addr;
        mem_wdata_d = head.col;
        mem_we_d    = 1'b1;
      end
      default: begin
        mem_we_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    frame_done_d  = frame_armed_q && bus.lcd_vblank && fifo_empty && (state_q != WR);
    frame_armed_d = !bus.lcd_vblank || (frame_armed_q && !frame_done_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      wr_ptr_q      <= 2'd0;
      rd_ptr_q      <= 2'd0;
      count_q       <= 3'd0;
      mem_addr_q    <= 15'd0;
      mem_we_q      <= 1'b0;
      mem_wdata_q   <= 2'd0;
      overflow_q    <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_armed_q <= 1'b1;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      mem_addr_q    <= mem_addr_d;
      mem_we_q      <= mem_we_d;
      mem_wdata_q   <= mem_wdata_d;
      overflow_q    <= overflow_d;
      frame_done_q  <= frame_done_d;
      frame_armed_q <= frame_armed_d;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_q[i] <= fifo_d[i];
      end
    end
  end

  assign bus.mem_addr       = mem_addr_q;
  assign bus.mem_we         = mem_we_q;
  assign bus.mem_wdata      = mem_wdata_q;
  assign bus.wfifo_overflow = overflow_q;
  assign bus.frame_done     = frame_done_q;
  // Read data is only meaningful in the ack cycle, when the RAM output is valid
  assign bus.rd_ack         = (state_q == RD_ACK);
  assign bus.rd_data        = (state_q == RD_ACK) ? bus.mem_rdata : 2'd0;

endmodule
